// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch queue entry type and constants
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fq_entry_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of fetched entries with flush priority over push and pop
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fq_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fq_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  fq_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & ~flush;
    do_pop  = pop & ~flush & ~empty;
    rd_d    = flush ? '0 : rd_q + {{(AW-1){1'b0}}, do_pop};
    wr_d    = flush ? '0 : wr_q + {{(AW-1){1'b0}}, do_push};
    count_d = flush ? '0 : count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (do_push) mem_q[wr_q] <= push_data;
    end
  end
  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, fault tagging and buffering of fetched instructions for decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 4,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic        dec_fault
);
  logic [31:0] pc_q, pc_d;
  logic push, pop, fault, fq_full, fq_empty;
  logic [$clog2(FQ_DEPTH):0] fq_count;
  fq_entry_t fq_head, fq_in;
  always_comb begin
    pop   = dec_valid & dec_ready & ~redirect_valid;
    push  = fetch_en & ~redirect_valid & (~fq_full | pop);
    fault = (pc_q[1:0] != 2'b00) | ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));
    fq_in = '{pc: pc_q, instr: imem_data, fault: fault};
    pc_d  = redirect_valid ? redirect_pc : push ? pc_q + 32'd4 : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fq_in),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fq_head),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );
  assign imem_addr = pc_q;
  assign dec_valid = ~fq_empty;
  assign dec_pc    = fq_head.pc;
  assign dec_instr = fq_head.instr;
  assign dec_fault = fq_head.fault;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed values
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, fetch_en, redirect_valid, dec_ready;
  logic [31:0] redirect_pc, imem_addr, imem_data, dec_pc, dec_instr;
  logic dec_valid, dec_fault;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  always #5 clk = ~clk;
  assign imem_data = (imem_addr[1:0] == 2'b00 && imem_addr < 32'h1000) ? (32'hA000_0000 | {22'b0, imem_addr[11:2]}) : NOP;
  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr),
    .dec_fault      (dec_fault)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = 1'b0;
    tick(2);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", dec_pc, 32'h0);
    check("rst_instr", dec_instr, NOP);
    check("rst_fault", 32'(dec_fault), 32'd0);
    rst = 1'b0;
    fetch_en = 1'b1;
    dec_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(dec_valid), 32'd1);
      check("stream_pc", dec_pc, 32'(4 * i));
      check("stream_instr", dec_instr, 32'hA000_0000 | 32'(i));
      check("stream_fault", 32'(dec_fault), 32'd0);
      tick();
    end
    dec_ready = 1'b0;
    redirect(32'h0);
    check("restart_valid", 32'(dec_valid), 32'd0);
    check("restart_addr", imem_addr, 32'h0);
    tick(8);
    check("full_count", 32'(dut.fq_count), 32'd4);
    check("full_addr", imem_addr, 32'h10);
    check("full_hold_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", dec_pc, 32'(4 * i));
      check("drain_instr", dec_instr, 32'hA000_0000 | 32'(i));
      tick();
      if (i == 0) begin
        check("popush_addr", imem_addr, 32'h14);
        check("popush_count", 32'(dut.fq_count), 32'd4);
      end
    end
    check("drain_next", dec_pc, 32'h10);
    fetch_en = 1'b0;
    tick();
    check("en_low_addr", imem_addr, 32'h20);
    check("en_low_count", 32'(dut.fq_count), 32'd3);
    check("en_low_head", dec_pc, 32'h14);
    fetch_en = 1'b1;
    redirect(32'h40);
    check("redir_valid", 32'(dec_valid), 32'd0);
    check("redir_count", 32'(dut.fq_count), 32'd0);
    check("redir_addr", imem_addr, 32'h40);
    tick();
    check("redir_pc", dec_pc, 32'h40);
    check("redir_instr", dec_instr, 32'hA000_0010);
    redirect(32'h42);
    tick();
    check("mis_pc0", dec_pc, 32'h42);
    check("mis_fault0", 32'(dec_fault), 32'd1);
    check("mis_instr0", dec_instr, NOP);
    tick();
    check("mis_pc1", dec_pc, 32'h46);
    check("mis_fault1", 32'(dec_fault), 32'd1);
    check("mis_instr1", dec_instr, NOP);
    redirect(32'hFFC);
    tick();
    check("last_pc", dec_pc, 32'hFFC);
    check("last_fault", 32'(dec_fault), 32'd0);
    check("last_instr", dec_instr, 32'hA000_03FF);
    tick();
    check("oor_pc", dec_pc, 32'h1000);
    check("oor_fault", 32'(dec_fault), 32'd1);
    check("oor_instr", dec_instr, NOP);
    redirect(32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", imem_addr, 32'h0);
    check("wrap_pc", dec_pc, 32'hFFFF_FFFC);
    check("wrap_fault", 32'(dec_fault), 32'd1);
    dec_ready = 1'b0;
    redirect(32'h80);
    tick(2);
    check("half_count", 32'(dut.fq_count), 32'd2);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    check("mid_rst_valid", 32'(dec_valid), 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc", dec_pc, 32'h0);
    check("mid_rst_instr", dec_instr, NOP);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that initiates requests to the instruction memory and buffers the returned instructions for decode. Holds the program counter and issues one word-aligned fetch address per cycle into the combinational-read instruction memory. Each instruction is captured into a small in-order fetch queue, tagged with its PC and a fault bit, and handed to decode over a valid/ready handshake. Branch and exception redirects from the back end flush the queue and restart fetch.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FQ_DEPTH, 4, fetch queue entries; power of two, ≥2
- IMEM_WORDS, 1024, instruction memory size in 32-bit words; used for the fault check

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  fetch is allowed this cycle; 0 holds the PC and suppresses pushes
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC
- imem_addr  out  32  fetch address driven to the instruction memory; equals pc_q
- imem_data  in  32  instruction word returned combinationally in the same cycle
- dec_valid  out  1  queue head holds a valid entry
- dec_ready  in  1  decode accepts the head entry this cycle
- dec_pc  out  32  PC of the head entry
- dec_instr  out  32  instruction of the head entry
- dec_fault  out  1  head entry was fetched from a misaligned or out-of-range PC

## Operation

- pc_q drives imem_addr directly. imem_data is sampled in the same cycle.
- **push** = fetch_en & ~redirect_valid & (count < FQ_DEPTH | pop).
- **pop** = dec_valid & dec_ready.
- On push:
  - Enqueue {pc_q, imem_data, fault}.
  - fault = (pc_q[1:0] != 0) | (pc_q[31:2] >= IMEM_WORDS).
  - pc_q <= pc_q + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- A faulting entry carries whatever imem_data returns, which is the NOP 32'h00000013. The fetch unit does not substitute its own value.
- A misaligned PC stays misaligned as it increments. Every subsequent entry is faulted until a redirect.
- **Redirect:**
  - Highest priority.
  - On the edge where redirect_valid=1: count <= 0, pc_q <= redirect_pc.
  - No push and no pop take effect, even if dec_ready=1.
- **Full queue:**
  - When count == FQ_DEPTH and there is no pop, pc_q holds and imem_addr is stable.
  - When count == FQ_DEPTH and a pop occurs in the same cycle, the push proceeds.
- **Empty queue:** simultaneous push and pop is not a bypass. The pushed entry becomes visible on the next cycle.
- **dec_* outputs:**
  - dec_valid = (count != 0).
  - dec_pc, dec_instr and dec_fault come from the head-entry registers.
  - While dec_valid=0 these are don't-care, but they must not produce X after reset.

## Timing

- Reset values:
  - pc_q = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, head and tail pointers = 0.
  - dec_valid = 0, dec_pc = 0, dec_instr = 32'h00000013, dec_fault = 0.
- Fetch-to-decode latency: 1 cycle. A word fetched in cycle N is presented with dec_valid=1 in cycle N+1.
- Redirect latency:
  - redirect_valid is asserted in cycle N.
  - imem_addr = redirect_pc in cycle N+1.
  - The first redirected entry is presented in cycle N+2.
- Sustained throughput: 1 instruction/cycle when dec_ready is held at 1.
- Reset mid-operation overrides redirect, push and pop. All state returns to reset values on that edge.
- Handshake:
  - dec_pc, dec_instr and dec_fault are stable while dec_valid=1 and dec_ready=0.
  - dec_valid may drop without a pop only because of a redirect.

## Structure

- Package fetch_pkg:
  - typedef fq_entry_t {logic [31:0] pc; logic [31:0] instr; logic fault;}
  - localparam NOP_INSTR = 32'h00000013
- Sub-module fetch_queue:
  - Synchronous FIFO of fq_entry_t, parameter DEPTH.
  - Ports: push, push_data, pop, flush, head, count, full, empty.
  - flush has priority over push and pop.
- fetch_unit contains the PC register, push/pop logic and fault computation, and instantiates fetch_queue. A top-level test wrapper connects it to the instruction memory.

## Test plan

- Reset, then fetch_en=1 and dec_ready=1, with memory words 0..7 preloaded. Required: dec_pc = 0,4,8,… on consecutive cycles, the first in cycle 1, dec_instr matches memory, dec_fault=0.
- dec_ready=0 for 8 cycles. Required: count saturates at 4 and imem_addr freezes at 0x10. After dec_ready returns to 1, entries 0x0..0xC drain in order with none lost or duplicated.
- Queue full, then dec_ready=1 for one cycle. Required: exactly one pop and one push in that cycle, and imem_addr advances to 0x14.
- Redirect to 0x40 while count=3 and dec_ready=1. Required: no pop is counted, dec_valid=0 the next cycle, and dec_pc=0x40 two cycles after the redirect.
- Redirect to 0x42, then redirect to 0x1000 (IMEM_WORDS=1024). Required: dec_fault=1 with dec_instr=0x00000013 for both, and dec_pc=0x42, 0x46 for the misaligned sequence.
- Assert rst while the queue is half full and a redirect is pending. Required: the next cycle shows dec_valid=0 and imem_addr=RESET_PC.
